// File: rtl/sprite_line_scheduler.sv
// sprite_line_scheduler: scans the sprite attribute table on each line_start
// and issues one sprite_drawer job per sprite that intersects the requested
// scanline, in ascending index order, waiting for each job to finish.
module sprite_line_scheduler #(
    parameter int unsigned N_SPRITES    = 32,
    parameter int unsigned MAX_PER_LINE = 16
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         sat_we,
    input  logic [$clog2(N_SPRITES)-1:0] sat_addr,
    input  logic [31:0]                  sat_wdata,
    input  logic                         line_start,
    input  logic [9:0]                   line,
    output logic                         drawer_start,
    output logic [9:0]                   col_base,
    output logic                         flip,
    output logic [7:0]                   frame_id,
    output logic [3:0]                   row_off,
    input  logic                         drawer_done,
    output logic                         busy,
    output logic                         line_done,
    output logic                         sprite_overflow,
    output logic                         overrun
);

    localparam int unsigned IDX_W = $clog2(N_SPRITES);
    localparam int unsigned CNT_W = $clog2(MAX_PER_LINE + 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_EVAL  = 3'd1;
    localparam logic [2:0] S_ISSUE = 3'd2;
    localparam logic [2:0] S_WAIT  = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    logic [31:0]      sat [N_SPRITES];
    logic [2:0]       state;
    logic [IDX_W-1:0] idx;
    logic [CNT_W-1:0] hit_cnt;
    logic [9:0]       line_q;

    logic [31:0] entry;
    logic        e_en;
    logic [9:0]  e_y;
    logic [10:0] diff;
    logic        hit;
    logic        last_idx;
    logic        cnt_full;
    logic        unused_rsv;

    // Entry under evaluation and the vertical hit test (11-bit, no wrap).
    always_comb begin
        entry    = sat[idx];
        e_en     = entry[31];
        e_y      = entry[29:20];
        diff     = {1'b0, line_q} - {1'b0, e_y};
        hit      = e_en && (line_q >= e_y) && (diff < 11'd16);
        last_idx = (idx == IDX_W'(N_SPRITES - 1));
        cnt_full = (hit_cnt == CNT_W'(MAX_PER_LINE));
    end

    // Reserved bits are stored in the table but have no effect.
    assign unused_rsv = ^entry[9:8];

    assign drawer_start = (state == S_ISSUE);
    assign line_done    = (state == S_DONE);
    assign busy         = (state == S_EVAL) || (state == S_ISSUE) || (state == S_WAIT);

    // Sprite attribute table: host writes land on the next edge, reset clears all.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < N_SPRITES; i++) begin
                sat[i] <= '0;
            end
        end else if (sat_we) begin
            sat[sat_addr] <= sat_wdata;
        end
    end

    // Scan FSM: evaluate entries one per cycle, issue a job per hit, wait for done.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state           <= S_IDLE;
            idx             <= '0;
            hit_cnt         <= '0;
            line_q          <= '0;
            col_base        <= '0;
            flip            <= 1'b0;
            frame_id        <= '0;
            row_off         <= '0;
            sprite_overflow <= 1'b0;
            overrun         <= 1'b0;
        end else begin
            overrun <= line_start && (state != S_IDLE);
            case (state)
                S_IDLE: begin
                    if (line_start) begin
                        line_q          <= line;
                        idx             <= '0;
                        hit_cnt         <= '0;
                        sprite_overflow <= 1'b0;
                        state           <= S_EVAL;
                    end
                end
                S_EVAL: begin
                    if (hit) begin
                        if (cnt_full) begin
                            sprite_overflow <= 1'b1;
                            state           <= S_DONE;
                        end else begin
                            col_base <= entry[19:10];
                            flip     <= entry[30];
                            frame_id <= entry[7:0];
                            row_off  <= diff[3:0];
                            state    <= S_ISSUE;
                        end
                    end else if (last_idx) begin
                        state <= S_DONE;
                    end else begin
                        idx <= idx + IDX_W'(1);
                    end
                end
                S_ISSUE: begin
                    hit_cnt <= hit_cnt + CNT_W'(1);
                    state   <= S_WAIT;
                end
                S_WAIT: begin
                    if (drawer_done) begin
                        if (last_idx) begin
                            state <= S_DONE;
                        end else begin
                            idx   <= idx + IDX_W'(1);
                            state <= S_EVAL;
                        end
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/sprite_line_scheduler.md
Name: sprite_line_scheduler

Overview:
- Upstream feeder of sprite_drawer: on each line_start, scans an internal sprite attribute table (SAT) for sprites that intersect the requested scanline.
- For every hit, issues one sprite_drawer job (start, col_base, flip, frame_id, row_off) and waits for that job's done before evaluating further sprites.
- Host writes the SAT through a simple write port.
- Sprites are issued in ascending index order, so higher-index sprites overwrite lower ones in the line buffer.

Parameters:
- N_SPRITES, 32, number of SAT entries; power of 2, 2..256.
- MAX_PER_LINE, 16, maximum jobs issued per line; further hits set sprite_overflow.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- sat_we  in  1  SAT write strobe
- sat_addr  in  $clog2(N_SPRITES)  SAT entry index
- sat_wdata  in  32  entry word: [31] en, [30] flip, [29:20] y, [19:10] x, [9:8] reserved, [7:0] frame_id
- line_start  in  1  one-cycle pulse that begins a scan
- line  in  10  scanline to prepare; sampled with line_start
- drawer_start  out  1  one-cycle job pulse to sprite_drawer.start
- col_base  out  10  sprite x
- flip  out  1  horizontal flip
- frame_id  out  8  sprite frame
- row_off  out  4  line - y
- drawer_done  in  1  sprite_drawer.done (level; high when idle)
- busy  out  1  high from the cycle after line_start is accepted until line_done
- line_done  out  1  one-cycle pulse when the scan completes
- sprite_overflow  out  1  more than MAX_PER_LINE hits on the current line; cleared on accepted line_start
- overrun  out  1  one-cycle pulse when line_start arrives while busy

Behaviour:
- Reset (reset=0, async):
  - All outputs 0; FSM goes to IDLE; index and hit count 0; latched line 0.
  - Every SAT entry cleared, so en=0.
  - Reset asserted mid-job abandons the job; the drawer is reset by the same net.
- SAT writes:
  - Accepted on any cycle, including during a scan; take effect on the next edge.
  - An entry being evaluated in the same cycle as its write uses the old value.
  - Reserved bits are stored but ignored.
- FSM states: IDLE, EVAL, ISSUE, WAIT, DONE.
- IDLE:
  - On line_start, latch line, clear index, hit count and sprite_overflow, then go to EVAL.
- EVAL (one cycle per entry), reading entry[index] combinationally:
  - Hit rule: en=1 AND line >= y AND (line - y) < 16, using unsigned 11-bit compare. There is no vertical wrap: y=1020 never hits line 2.
  - Hit with hit count < MAX_PER_LINE: register col_base=x, flip, frame_id, row_off=(line-y)[3:0]; go to ISSUE.
  - Hit with hit count = MAX_PER_LINE: set sprite_overflow; go to DONE.
  - Miss: if index = N_SPRITES-1 go to DONE, else increment index and stay in EVAL.
- ISSUE:
  - drawer_start=1 for exactly this one cycle; job fields stay stable from ISSUE until the next ISSUE.
  - Increment hit count; go to WAIT.
- WAIT:
  - drawer_done is already 0 in the first WAIT cycle (the drawer registers start).
  - Stay until drawer_done=1, then go to DONE if index = N_SPRITES-1, else increment index and go to EVAL.
  - A drawer_done that is already high in the first WAIT cycle is a protocol error; the block still treats it as completion.
- DONE:
  - line_done=1 for one cycle; busy=0 in the same cycle; go to IDLE.
- line_start while busy (EVAL/ISSUE/WAIT/DONE):
  - Ignored; overrun=1 for one cycle; the current scan continues unchanged.
- Timing:
  - line_start sampled at edge 0 gives EVAL of entry 0 in cycle 1.
  - With no hits, line_done rises in cycle N_SPRITES+1.
  - Each hit adds 1 ISSUE cycle plus the WAIT duration.
- Width rules:
  - row_off is the low 4 bits of an 11-bit difference known to be < 16.
  - col_base is passed through unmodified; horizontal clipping is the drawer/line-buffer's responsibility.

Test Plan:
- Empty SAT, line_start with line=100 -> zero drawer_start pulses; line_done exactly 33 cycles after line_start (N_SPRITES=32); sprite_overflow=0.
- Entry 3 = {en=1, flip=1, y=90, x=200, frame=0x15}, line=100; drawer model with 17-cycle done-low -> one job with col_base=200, flip=1, frame_id=0x15, row_off=10; line_done after the job completes.
- Entries 2 and 7 both hit line 50 at y=40 and y=35 -> jobs in order 2 (row_off=10) then 7 (row_off=15); drawer_start for 7 only after done returns high; line=51 gives only entry 2 (7 now misses, since 16 is not < 16).
- 20 enabled entries, all y=0, line=5 -> exactly 16 jobs; sprite_overflow=1 after the 17th hit; next line_start clears it.
- line_start while in WAIT -> overrun pulse; scan continues with the original line; no extra jobs.
- Async reset pulled low mid-WAIT -> all outputs 0 immediately; after release, SAT reads empty (line_start produces no jobs).
